lcd_text_buffer: RTL

- Character frame buffer that sits directly upstream of the hd44780 driver.
- Accepts a byte stream over a valid/ready interface and interprets printable characters plus a small set of terminal control codes.
- Stores the result in a 4x16-cell text RAM that the driver reads through its address/data port.
- Issues the driver's print trigger whenever the buffer contents change and the driver is idle.

---
 rtl/lcd_text_buffer.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/lcd_text_buffer.sv
// rtl/lcd_text_buffer.sv - 4x16 character frame buffer with terminal control codes feeding the hd44780 driver
module lcd_text_buffer #(
  parameter int LINE_WIDTH = 16,
  parameter int NUM_LINES  = 4,
  parameter int ADDR_BITS  = 6,
  parameter int BUSY_WAIT  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [7:0]           in_data,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [7:0]           rd_data,
  input  logic                 lcd_busy,
  output logic                 lcd_trg,
  output logic [ADDR_BITS-1:0] cursor,
  output logic                 dirty
);
  localparam int DEPTH     = LINE_WIDTH * NUM_LINES;
  localparam int COL_BITS  = $clog2(LINE_WIDTH);
  localparam int LINE_BITS = ADDR_BITS - COL_BITS;
  localparam int WAIT_BITS = $clog2(BUSY_WAIT + 1);
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(DEPTH - 1);

  typedef enum logic [1:0] {INIT_CLEAR, IDLE, CLEAR} wstate_t;
  typedef enum logic [1:0] {T_IDLE, T_WAIT_HI, T_WAIT_LO} tstate_t;

  wstate_t wstate, wstate_nxt;
  tstate_t tstate, tstate_nxt;

  logic [7:0]           mem [DEPTH];
  logic [ADDR_BITS-1:0] clr_addr, cursor_nxt, wr_addr;
  logic [7:0]           wr_data;
  logic                 wr_en, set_dirty, accept, clearing;
  logic [COL_BITS-1:0]  col;
  logic [LINE_BITS-1:0] line, line_nxt;
  logic [WAIT_BITS-1:0] wait_cnt;

  assign col      = cursor[COL_BITS-1:0];
  assign line     = cursor[ADDR_BITS-1:COL_BITS];
  assign line_nxt = (line == LINE_BITS'(NUM_LINES - 1)) ? '0 : line + 1'b1;
  assign accept   = in_valid & in_ready;
  assign clearing = (wstate != IDLE);

  always_ff @(posedge clk) begin
    if (!rst) wstate <= INIT_CLEAR;
    else      wstate <= wstate_nxt;
  end

  always_comb begin
    wstate_nxt = wstate;
    case (wstate)
      INIT_CLEAR, CLEAR: if (clr_addr == LAST_ADDR) wstate_nxt = IDLE;
      IDLE:              if (accept && in_data == 8'h0C) wstate_nxt = CLEAR;
      default:           wstate_nxt = INIT_CLEAR;
    endcase
  end

  // Blank fill is the default write data; backspace reuses it.
  always_comb begin
    in_ready   = (wstate == IDLE);
    wr_en      = 1'b0;
    wr_addr    = clr_addr;
    wr_data    = 8'h20;
    set_dirty  = 1'b0;
    cursor_nxt = cursor;
    case (wstate)
      INIT_CLEAR, CLEAR: wr_en = 1'b1;
      IDLE: if (accept) begin
        if (in_data >= 8'h20 && in_data <= 8'h7E) begin
          wr_en      = 1'b1;
          wr_addr    = cursor;
          wr_data    = in_data;
          set_dirty  = 1'b1;
          cursor_nxt = (cursor == LAST_ADDR) ? '0 : cursor + 1'b1;
        end else begin
          case (in_data)
            8'h0A: cursor_nxt = {line_nxt, {COL_BITS{1'b0}}};
            8'h0D: cursor_nxt = {line, {COL_BITS{1'b0}}};
            8'h08: if (col != '0) begin
              cursor_nxt = cursor - 1'b1;
              wr_en      = 1'b1;
              wr_addr    = cursor - 1'b1;
              set_dirty  = 1'b1;
            end
            8'h0C: begin
              cursor_nxt = '0;
              set_dirty  = 1'b1;
            end
            default: ;
          endcase
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) tstate <= T_IDLE;
    else      tstate <= tstate_nxt;
  end

  always_comb begin
    tstate_nxt = tstate;
    case (tstate)
      T_IDLE:    if (lcd_trg) tstate_nxt = T_WAIT_HI;
      T_WAIT_HI: begin
        if (lcd_busy)                                      tstate_nxt = T_WAIT_LO;
        else if (wait_cnt == WAIT_BITS'(BUSY_WAIT - 1))    tstate_nxt = T_IDLE;
      end
      T_WAIT_LO: if (!lcd_busy) tstate_nxt = T_IDLE;
      default:   tstate_nxt = T_IDLE;
    endcase
  end

  // Gating on lcd_busy combinationally guarantees no request while the driver is busy.
  always_comb begin
    lcd_trg = (tstate == T_IDLE) && dirty && !lcd_busy && !clearing;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cursor   <= '0;
      clr_addr <= '0;
      dirty    <= 1'b0;
      wait_cnt <= '0;
      rd_data  <= 8'h00;
    end else begin
      cursor   <= cursor_nxt;
      clr_addr <= clearing ? clr_addr + 1'b1 : '0;
      dirty    <= set_dirty | (dirty & ~lcd_trg);
      wait_cnt <= (tstate == T_WAIT_HI) ? wait_cnt + 1'b1 : '0;
      rd_data  <= mem[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst && wr_en) mem[wr_addr] <= wr_data;
  end
endmodule
